// File: rtl/nec_ir_pkg.sv
// NEC IR decoder shared types: FSM states, frame layout and pulse-width windows.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nec_ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_RPT_STOP
    } ir_state_t;

    // Bits arrive LSB-first, so after 32 right-shifts the first byte on air sits at [7:0].
    typedef struct packed {
        logic [7:0] ncmd;
        logic [7:0] cmd;
        logic [7:0] naddr;
        logic [7:0] addr;
    } nec_frame_t;

    // Widths in ticks (1 tick = 1/10 NEC unit), inclusive bounds.
    localparam logic [7:0] LEAD_MARK_MIN  = 8'd128;
    localparam logic [7:0] LEAD_MARK_MAX  = 8'd192;
    localparam logic [7:0] LEAD_SPACE_MIN = 8'd64;
    localparam logic [7:0] LEAD_SPACE_MAX = 8'd96;
    localparam logic [7:0] RPT_SPACE_MIN  = 8'd32;
    localparam logic [7:0] RPT_SPACE_MAX  = 8'd48;
    localparam logic [7:0] BIT_MARK_MIN   = 8'd6;
    localparam logic [7:0] BIT_MARK_MAX   = 8'd14;
    localparam logic [7:0] ZERO_MIN       = 8'd6;
    localparam logic [7:0] ZERO_MAX       = 8'd14;
    localparam logic [7:0] ONE_MIN        = 8'd22;
    localparam logic [7:0] ONE_MAX        = 8'd38;
    localparam logic [7:0] WIDTH_SAT      = 8'd255;

    function automatic logic in_window(input logic [7:0] w, input logic [7:0] lo,
                                       input logic [7:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
// Latency: first tick TICK_DIV clocks after reset release.
// Backpressure: none; restarted only by reset.
module ir_tick_gen #(
    parameter int TICK_DIV = 563
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1 and flag the wrap as the tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(TICK_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder: sticky cmd/addr/valid/rpt/ovr for the CPU, one-cycle err on abort.
// Latency: outputs update 4 clks after the raw ir_in edge ending the stop mark.
// Backpressure: none; ack clears flags, a commit while valid=1 sets ovr.
module nec_ir_receiver
    import nec_ir_pkg::*;
#(
    parameter int TICK_DIV    = 563,
    parameter bit STRICT_ADDR = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_in,
    input  logic       ack,
    output logic [7:0] cmd,
    output logic [7:0] addr,
    output logic       valid,
    output logic       rpt,
    output logic       ovr,
    output logic       err
);

    logic [1:0] sync_q;
    logic       mark;
    logic       mark_q;
    logic       mark_edge;
    logic       mark_rise;
    logic       mark_fall;
    logic       tick;
    logic [7:0] width;

    ir_state_t  state, state_n;
    nec_frame_t frame_sr, frame_n;
    logic [4:0] bit_idx, bit_idx_n;
    logic       go_frame, go_rpt, go_err;
    logic       frame_q, rpt_q, err_q;
    logic       frame_ok;
    logic       seen;

    ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Carrier is active-low on the pin; mark=1 means carrier present.
    assign mark      = ~sync_q[1];
    assign mark_edge = mark ^ mark_q;
    assign mark_rise = mark_edge & mark;
    assign mark_fall = mark_edge & ~mark;

    // Two-flop synchronizer plus previous-value register for edge detection;
    // resets to the idle (no carrier) level so reset never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            mark_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ir_in};
            mark_q <= mark;
        end
    end

    // Phase width: cleared on each edge, counts ticks, saturates at WIDTH_SAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            width <= '0;
        end else if (mark_edge) begin
            width <= '0;
        end else if (tick && (width != WIDTH_SAT)) begin
            width <= width + 8'd1;
        end
    end

    assign frame_ok = ((frame_sr.cmd ^ frame_sr.ncmd) == 8'hFF) &&
                      (!STRICT_ADDR || ((frame_sr.addr ^ frame_sr.naddr) == 8'hFF));

    // Decoder state, shift register, bit index and the registered decision pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            frame_sr <= '0;
            bit_idx  <= '0;
            frame_q  <= 1'b0;
            rpt_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            frame_sr <= frame_n;
            bit_idx  <= bit_idx_n;
            frame_q  <= go_frame;
            rpt_q    <= go_rpt;
            err_q    <= go_err;
        end
    end

    // Edge-driven protocol walk; any out-of-window width or a stalled line aborts to IDLE.
    always_comb begin
        state_n   = state;
        frame_n   = frame_sr;
        bit_idx_n = bit_idx;
        go_frame  = 1'b0;
        go_rpt    = 1'b0;
        go_err    = 1'b0;

        if ((state != ST_IDLE) && !mark_edge && (width == WIDTH_SAT)) begin
            go_err  = 1'b1;
            state_n = ST_IDLE;
        end else if (mark_edge) begin
            case (state)
                ST_IDLE: begin
                    if (mark_rise) state_n = ST_LEAD_MARK;
                end
                ST_LEAD_MARK: begin
                    if (mark_fall && in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                        state_n = ST_LEAD_SPACE;
                    end else begin
                        go_err  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (mark_rise && in_window(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                        state_n   = ST_BIT_MARK;
                        bit_idx_n = '0;
                    end else if (mark_rise && in_window(width, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                        state_n = ST_RPT_STOP;
                    end else begin
                        go_err  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_BIT_MARK: begin
                    if (mark_fall && in_window(width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        state_n = ST_BIT_SPACE;
                    end else begin
                        go_err  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_BIT_SPACE: begin
                    if (mark_rise && (in_window(width, ZERO_MIN, ZERO_MAX) ||
                                      in_window(width, ONE_MIN, ONE_MAX))) begin
                        frame_n   = {in_window(width, ONE_MIN, ONE_MAX), frame_sr[31:1]};
                        bit_idx_n = bit_idx + 5'd1;
                        state_n   = (bit_idx == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                    end else begin
                        go_err  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
                ST_STOP_MARK: begin
                    state_n = ST_IDLE;
                    if (mark_fall && in_window(width, BIT_MARK_MIN, BIT_MARK_MAX) && frame_ok) begin
                        go_frame = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                ST_RPT_STOP: begin
                    state_n = ST_IDLE;
                    if (mark_fall && in_window(width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
                        go_rpt = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // CPU-facing registers: commits beat a coincident ack; repeats need a prior frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd   <= '0;
            addr  <= '0;
            valid <= 1'b0;
            rpt   <= 1'b0;
            ovr   <= 1'b0;
            err   <= 1'b0;
            seen  <= 1'b0;
        end else begin
            err <= err_q;
            if (frame_q) begin
                cmd   <= frame_sr.cmd;
                addr  <= frame_sr.addr;
                valid <= 1'b1;
                rpt   <= 1'b0;
                ovr   <= ack ? 1'b0 : (ovr | valid);
                seen  <= 1'b1;
            end else if (rpt_q && seen) begin
                valid <= 1'b1;
                rpt   <= 1'b1;
                ovr   <= ack ? 1'b0 : (ovr | valid);
            end else if (ack) begin
                valid <= 1'b0;
                rpt   <= 1'b0;
                ovr   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Self-checking bench for nec_ir_receiver with randomized pulse widths and frame contents.
// Latency: checks outputs 4 clks after the stop-mark release.
// Backpressure: n/a.
module tb_nec_ir_receiver;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ir_in;
    logic       ack;
    logic [7:0] cmd;
    logic [7:0] addr;
    logic       valid;
    logic       rpt;
    logic       ovr;
    logic       err;

    nec_ir_receiver #(.TICK_DIV(TDIV), .STRICT_ADDR(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .ir_in (ir_in),
        .ack   (ack),
        .cmd   (cmd),
        .addr  (addr),
        .valid (valid),
        .rpt   (rpt),
        .ovr   (ovr),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    int err_cyc  = 0;
    int err_long = 0;
    logic err_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Count err pulses and flag any pulse longer than one cycle.
    always @(negedge clk) begin
        if (err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
            if (err_prev) err_long = err_long + 1;
        end
        err_prev = err;
    end

    // Behavioural model of the CPU-visible state.
    logic [7:0] m_cmd, m_addr;
    logic       m_valid, m_rpt, m_ovr, m_seen;

    function automatic void model_clear();
        m_cmd = 8'h00; m_addr = 8'h00;
        m_valid = 1'b0; m_rpt = 1'b0; m_ovr = 1'b0; m_seen = 1'b0;
    endfunction

    function automatic void model_ack();
        m_valid = 1'b0; m_rpt = 1'b0; m_ovr = 1'b0;
    endfunction

    // Returns 1 when the frame must be rejected with err.
    function automatic logic model_frame(input logic [31:0] f);
        logic [7:0] a, c, nc;
        a  = f[7:0];
        c  = f[23:16];
        nc = f[31:24];
        if ((c ^ nc) != 8'hFF) return 1'b1;
        m_ovr   = m_ovr | m_valid;
        m_valid = 1'b1;
        m_rpt   = 1'b0;
        m_cmd   = c;
        m_addr  = a;
        m_seen  = 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_repeat();
        if (m_seen) begin
            m_ovr   = m_ovr | m_valid;
            m_valid = 1'b1;
            m_rpt   = 1'b1;
        end
    endfunction

    function automatic int rr(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // All line changes happen 1 time unit after a rising clock edge.
    task automatic hold(input logic lvl, input int ticks);
        ir_in = lvl;
        repeat (ticks * TDIV) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, rr(8, 12));
            hold(1'b1, f[i] ? rr(26, 34) : rr(8, 12));
        end
    endtask

    task automatic send_frame_body(input logic [31:0] f);
        hold(1'b0, rr(150, 170));
        hold(1'b1, rr(75, 88));
        send_bits(f, 32);
        hold(1'b0, rr(8, 12));
    endtask

    task automatic send_frame(input logic [31:0] f);
        send_frame_body(f);
        ir_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_repeat();
        hold(1'b0, rr(150, 170));
        hold(1'b1, rr(37, 43));
        hold(1'b0, rr(8, 12));
        ir_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ir_in = 1'b1;
        ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        model_ack();
    endtask

    task automatic test_reset();
        do_reset();
        hold(1'b1, 5);
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state got=%h want=00000", {cmd, addr, valid, rpt, ovr, err});
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] f;
        logic        e;
        int          e0;
        do_reset();
        e0 = err_cnt;
        f  = {8'hBA, 8'h45, 8'hFF, 8'h00};
        e  = model_frame(f);
        send_frame(f);
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e}) begin
            failures++;
            $display("FAIL basic_frame got=%h want=%h", {cmd, addr, valid, rpt, ovr, err},
                     {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e});
        end
        checks++;
        if (cmd !== 8'h45 || valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_cmd got cmd=%h valid=%b want cmd=45 valid=1", cmd, valid);
        end
        hold(1'b1, 10);
        checks++;
        if (err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL basic_no_err got=%0d want=0", err_cnt - e0);
        end
    endtask

    task automatic test_bad_check();
        logic [31:0] f;
        logic        e;
        int          e0;
        do_reset();
        e0 = err_cnt;
        f  = {8'hBB, 8'h45, 8'hFF, 8'h00};
        e  = model_frame(f);
        send_frame(f);
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e}) begin
            failures++;
            $display("FAIL bad_check got=%h want=%h", {cmd, addr, valid, rpt, ovr, err},
                     {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e});
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL bad_check_err_width got=%b want=0", err);
        end
        hold(1'b1, 10);
        checks++;
        if (err_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL bad_check_err_count got=%0d want=1", err_cnt - e0);
        end
    endtask

    task automatic test_repeat();
        logic [31:0] f;
        logic        e;
        do_reset();
        f = {8'hE9, 8'h16, 8'hA5, 8'h5A};
        e = model_frame(f);
        send_frame(f);
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e}) begin
            failures++;
            $display("FAIL repeat_first_frame got=%h want=%h", {cmd, addr, valid, rpt, ovr, err},
                     {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e});
        end
        hold(1'b1, 20);
        model_repeat();
        send_repeat();
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, 1'b0}) begin
            failures++;
            $display("FAIL repeat_code got=%h want=%h", {cmd, addr, valid, rpt, ovr, err},
                     {m_cmd, m_addr, m_valid, m_rpt, m_ovr, 1'b0});
        end
        checks++;
        if (rpt !== 1'b1 || ovr !== 1'b1 || cmd !== 8'h16) begin
            failures++;
            $display("FAIL repeat_flags got rpt=%b ovr=%b cmd=%h want 1 1 16", rpt, ovr, cmd);
        end
        pulse_ack();
        checks++;
        if ({valid, rpt, ovr} !== {m_valid, m_rpt, m_ovr}) begin
            failures++;
            $display("FAIL repeat_ack got=%b want=%b", {valid, rpt, ovr}, {m_valid, m_rpt, m_ovr});
        end
    endtask

    task automatic test_repeat_after_reset();
        int e0;
        do_reset();
        e0 = err_cnt;
        model_repeat();
        send_repeat();
        hold(1'b1, 10);
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, 1'b0}) begin
            failures++;
            $display("FAIL repeat_unseen got=%h want=%h", {cmd, addr, valid, rpt, ovr, err},
                     {m_cmd, m_addr, m_valid, m_rpt, m_ovr, 1'b0});
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL repeat_unseen_err got=%0d want=0", err_cnt - e0);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] f;
        logic        e;
        int          e0, t0, d;
        e0 = err_cnt;
        hold(1'b0, 160);
        t0 = cyc;
        hold(1'b1, 300);
        checks++;
        if (err_cnt - e0 !== 1) begin
            failures++;
            $display("FAIL timeout_err_count got=%0d want=1", err_cnt - e0);
        end
        d = err_cyc - t0;
        checks++;
        if (d < 1000 || d > 1050) begin
            failures++;
            $display("FAIL timeout_err_time got=%0d clks want 1000..1050", d);
        end
        f = {8'hF3, 8'h0C, 8'h00, 8'h21};
        e = model_frame(f);
        send_frame(f);
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e}) begin
            failures++;
            $display("FAIL timeout_recover got=%h want=%h", {cmd, addr, valid, rpt, ovr, err},
                     {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] f;
        logic        e;
        int          e0;
        f  = {8'h8E, 8'h71, 8'h3C, 8'hC3};
        e0 = err_cnt;
        hold(1'b0, 160);
        hold(1'b1, 80);
        send_bits(f, 15);
        hold(1'b0, 10);
        ir_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        hold(1'b1, 20);
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== 20'h0 || err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL reset_mid_frame got=%h errs=%0d want=00000 errs=0",
                     {cmd, addr, valid, rpt, ovr, err}, err_cnt - e0);
        end
        e = model_frame(f);
        send_frame(f);
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e}) begin
            failures++;
            $display("FAIL reset_mid_next got=%h want=%h", {cmd, addr, valid, rpt, ovr, err},
                     {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e});
        end
    endtask

    task automatic test_ack_coincide();
        logic [31:0] f;
        logic        e;
        hold(1'b1, 10);
        f = {8'h55, 8'hAA, 8'h12, 8'h34};
        e = model_frame(f);
        m_ovr = 1'b0;
        send_frame_body(f);
        ir_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        checks++;
        if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e}) begin
            failures++;
            $display("FAIL ack_coincide got=%h want=%h", {cmd, addr, valid, rpt, ovr, err},
                     {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            logic [7:0]  a, na, c, nc;
            logic [31:0] f;
            logic        e;
            int          e0;
            hold(1'b1, 10);
            if ($urandom_range(1, 0) == 1) pulse_ack();
            a  = 8'($urandom);
            na = 8'($urandom);
            c  = 8'($urandom);
            nc = ~c;
            if ($urandom_range(3, 0) == 0) nc = nc ^ 8'($urandom_range(255, 1));
            f  = {nc, c, na, a};
            e0 = err_cnt;
            e  = model_frame(f);
            send_frame(f);
            checks++;
            if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e}) begin
                failures++;
                $display("FAIL random_frame[%0d] f=%h got=%h want=%h", n, f,
                         {cmd, addr, valid, rpt, ovr, err}, {m_cmd, m_addr, m_valid, m_rpt, m_ovr, e});
            end
            hold(1'b1, 10);
            checks++;
            if (err_cnt - e0 !== int'(e)) begin
                failures++;
                $display("FAIL random_err_count[%0d] got=%0d want=%0d", n, err_cnt - e0, e);
            end
            if ($urandom_range(1, 0) == 1) begin
                model_repeat();
                send_repeat();
                checks++;
                if ({cmd, addr, valid, rpt, ovr, err} !== {m_cmd, m_addr, m_valid, m_rpt, m_ovr, 1'b0}) begin
                    failures++;
                    $display("FAIL random_repeat[%0d] got=%h want=%h", n, {cmd, addr, valid, rpt, ovr, err},
                             {m_cmd, m_addr, m_valid, m_rpt, m_ovr, 1'b0});
                end
            end
        end
    endtask

    task automatic test_err_width();
        checks++;
        if (err_long !== 0) begin
            failures++;
            $display("FAIL err_pulse_width got=%0d long pulses want=0", err_long);
        end
    endtask

    initial begin
        reset = 1'b1;
        ir_in = 1'b1;
        ack   = 1'b0;
        model_clear();
        test_reset();
        test_basic_frame();
        test_bad_check();
        test_repeat();
        test_repeat_after_reset();
        test_timeout();
        test_reset_mid_frame();
        test_ack_coincide();
        test_random();
        test_err_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
